// File: rtl/pipe_barrel_shifter_if.sv
// Handshake bundle for pipe_barrel_shifter: valid/ready operand input,
// valid/ready result output and a pipeline-occupancy flag.
interface pipe_barrel_shifter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Fully pipelined barrel shifter/rotator: stage s conditionally shifts by 2^s,
// every stage registered, with per-stage valid/ready backpressure.
module pipe_barrel_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipe_barrel_shifter_if.slave bus
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  // Per-stage result registers; sidebands exist only for stages that feed another stage.
  logic [CNT_W-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [CNT_W];
  logic [WIDTH-1:0] data_d [CNT_W];
  logic [CNT_W-1:0] cnt_q  [CNT_W-1];
  logic [CNT_W-1:0] cnt_d  [CNT_W-1];
  logic [1:0]       op_q   [CNT_W-1];
  logic [1:0]       op_d   [CNT_W-1];
  logic [CNT_W-2:0] sign_q, sign_d;

  // Inputs seen by each stage: the bus for stage 0, the previous stage otherwise.
  logic [CNT_W-1:0] src_valid;
  logic [WIDTH-1:0] src_data [CNT_W];
  logic [CNT_W-1:0] src_cnt  [CNT_W];
  logic [1:0]       src_op   [CNT_W];
  logic [CNT_W-1:0] src_sign;
  logic [CNT_W-1:0] stage_ready;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input logic             sign,
                                                input int               amt);
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] r;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
      OP_SLL:  r = d << amt;
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
      default: r = (d >> amt) | (fill_mask & {WIDTH{sign}});
    endcase
    return r;
  endfunction

  // A stage can load if it is empty or its occupant leaves this cycle.
  always_comb begin
    logic down_ready;
    down_ready = bus.out_ready;
    for (int s = CNT_W - 1; s >= 0; s--) begin
      stage_ready[s] = !valid_q[s] || down_ready;
      down_ready     = stage_ready[s];
    end
  end

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_cnt[0]   = bus.in_cnt;
    src_op[0]    = bus.in_op;
    src_sign[0]  = bus.in_data[WIDTH-1];
    for (int s = 1; s < CNT_W; s++) begin
      src_valid[s] = valid_q[s-1];
      src_data[s]  = data_q[s-1];
      src_cnt[s]   = cnt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_sign[s]  = sign_q[s-1];
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so a
    // missed branch holds the register instead of inferring a latch.
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    for (int s = 0; s < CNT_W; s++) begin
      if (stage_ready[s]) begin
        valid_d[s] = src_valid[s];
        // Payload only moves with a valid entry, so idle X inputs never reach out_data.
        if (src_valid[s]) begin
          data_d[s] = src_cnt[s][s] ? shift_by(src_data[s], src_op[s], src_sign[s], 1 << s)
                                    : src_data[s];
        end
      end
    end
    for (int s = 0; s < CNT_W - 1; s++) begin
      if (stage_ready[s] && src_valid[s]) begin
        cnt_d[s]  = src_cnt[s];
        op_d[s]   = src_op[s];
        sign_d[s] = src_sign[s];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update
  // together from pre-edge values, which is what makes the pipeline shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath arrays are reset too, not just valids, so out_data reads
      // zero after reset and no stale operand is ever observable.
      valid_q <= '0;
      sign_q  <= '0;
      for (int s = 0; s < CNT_W; s++) data_q[s] <= '0;
      for (int s = 0; s < CNT_W - 1; s++) begin
        cnt_q[s] <= '0;
        op_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = stage_ready[0];
  assign bus.out_valid = valid_q[CNT_W-1];
  assign bus.out_data  = data_q[CNT_W-1];
  assign bus.busy      = |valid_q;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed and scoreboarded checks of pipe_barrel_shifter at WIDTH=16:
// latency, per-op results, throughput, backpressure, random stalls and reset flush.
module tb_pipe_barrel_shifter;

  localparam int W = 16;
  localparam int C = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [C-1:0] cnt;
    logic [1:0]   op;
  } op_t;

  logic clk = 1'b0;
  logic rst;

  pipe_barrel_shifter_if #(.WIDTH(W), .CNT_W(C)) bus ();

  pipe_barrel_shifter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;
  op_t          send_q[$];
  logic [W-1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model written bit-by-bit, independent of the stage structure.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [C-1:0] c,
                                         input logic [1:0] op);
    logic [W-1:0] r;
    int ci;
    ci = int'(c);
    r  = '0;
    case (op)
      2'b00: for (int i = 0; i < W; i++) r[i] = d[(i - ci + W) % W];
      2'b01: r = d << c;
      2'b10: for (int i = 0; i < W; i++) r[i] = d[(i + ci) % W];
      default: r = W'($signed(d) >>> c);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    bus.in_cnt   = 'x;
    bus.in_op    = 'x;
  endtask

  // One clock of queue-driven traffic; scoreboards both transfers.
  task automatic cycle(input bit ordy);
    bit           stalled;
    logic [W-1:0] stall_data;
    if (send_q.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = send_q[0].data;
      bus.in_cnt   = send_q[0].cnt;
      bus.in_op    = send_q[0].op;
    end else begin
      drive_idle();
    end
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      check("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(send_q[0].data, send_q[0].cnt, send_q[0].op));
      void'(send_q.pop_front());
    end
    stalled    = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
    @(posedge clk);
    #1;
    if (stalled) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data", 32'(bus.out_data), 32'(stall_data));
    end
  endtask

  // Single op into an empty pipe with out_ready high; checks exact latency.
  task automatic run_single(input logic [W-1:0] d, input logic [C-1:0] c,
                            input logic [1:0] op, input logic [W-1:0] exp, input string tag);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_cnt    = c;
    bus.in_op     = op;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive_idle();
    for (int k = 0; k < C - 1; k++) begin
      check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'(exp));
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(bus.out_valid | bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned base;
    op_t o;

    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_single(16'h8001, 4'd4,  2'b00, 16'h0018, "rol4");
    run_single(16'h8001, 4'd4,  2'b01, 16'h0010, "sll4");
    run_single(16'h8001, 4'd1,  2'b10, 16'hC000, "ror1");
    run_single(16'h8000, 4'd15, 2'b11, 16'hFFFF, "sra15_neg");
    run_single(16'h4000, 4'd2,  2'b11, 16'h1000, "sra2_pos");
    run_single(16'h8001, 4'd15, 2'b00, 16'hC000, "rol15");
    run_single(16'h7FFF, 4'd15, 2'b11, 16'h0000, "sra15_pos");
    run_single(16'hA5C3, 4'd0,  2'b10, 16'hA5C3, "ror0");
    run_single(16'hA5C3, 4'd0,  2'b11, 16'hA5C3, "sra0");

    // Back-to-back stream: 16 ops must fully drain in exactly 16 + 4 cycles.
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      o.data = 16'($urandom);
      o.cnt  = (i % 5 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      o.op   = 2'($urandom_range(0, 3));
      send_q.push_back(o);
    end
    for (int i = 0; i < 20; i++) cycle(1'b1);
    check("stream_sent", 32'(send_q.size()), 32'd0);
    check("stream_count", n_out - base, 32'd16);

    // Backpressure: only four entries fit while the consumer stalls.
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      o.data = 16'h1111 * 16'(i + 1);
      o.cnt  = 4'(i * 3);
      o.op   = 2'(i);
      send_q.push_back(o);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0);
    check("bp_accepted", 32'(exp_q.size()), 32'd4);
    check("bp_pending", 32'(send_q.size()), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 30 && (send_q.size() != 0 || exp_q.size() != 0); i++) cycle(1'b1);
    check("bp_drain_count", n_out - base, 32'd6);

    // Random consumer stalls over 200 ops.
    base = n_out;
    for (int i = 0; i < 200; i++) begin
      o.data = 16'($urandom);
      o.cnt  = 4'($urandom_range(0, 15));
      o.op   = 2'($urandom_range(0, 3));
      send_q.push_back(o);
    end
    for (int i = 0; i < 3000 && (send_q.size() != 0 || exp_q.size() != 0); i++)
      cycle(1'($urandom_range(0, 1)));
    check("rand_pending", 32'(send_q.size() + exp_q.size()), 32'd0);
    check("rand_count", n_out - base, 32'd200);

    // Reset with three ops in flight: they and the op offered during reset vanish.
    for (int i = 0; i < 3; i++) begin
      o.data = 16'hF00F ^ 16'(i);
      o.cnt  = 4'(i + 1);
      o.op   = 2'b01;
      send_q.push_back(o);
    end
    repeat (3) cycle(1'b1);
    check("flight_busy", 32'(bus.busy), 32'd1);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.in_cnt    = 4'd1;
    bus.in_op     = 2'b01;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_data", 32'(bus.out_data), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    base = n_out;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    check("flush_no_output", n_out - base, 32'd0);
    run_single(16'h00F0, 4'd4, 2'b01, 16'h0F00, "post_flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_barrel_shifter.md
Name: pipe_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter/rotator for the ALU shift path.
- Generalises the fixed 16-bit, single-stage shift-by-4 mux stage to WIDTH bits with log2(WIDTH) registered stages; stage k shifts by 2^k.
- Adds a valid/ready handshake on both sides with per-stage backpressure, and an arithmetic-right mode.
- Sits between operand select and the writeback mux; one operation can enter per cycle.

Parameters:
WIDTH, 16, datapath width in bits; must be a power of 2, at least 4.
CNT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  the in_data/in_cnt/in_op triple is valid.
in_ready  output  1  the block accepts input this cycle (combinational).
in_data  input  WIDTH  operand to shift.
in_cnt  input  CNT_W  shift amount, 0..WIDTH-1.
in_op  input  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right arithmetic.
out_valid  output  1  out_data is valid.
out_ready  input  1  the consumer accepts out_data this cycle.
out_data  output  WIDTH  shift result.
busy  output  1  at least one stage holds a valid entry.

Behaviour:
- Stage registers: CNT_W pipeline stages, s = 0..CNT_W-1. Each stage holds valid_s, data_s, the remaining count bits, and op.
- Stage s datapath: applies a shift of 2^s to its input when cnt bit s = 1, otherwise passes the data through. Stage s takes its input from in_* when s = 0, otherwise from stage s-1.
- Fill rules per op:
  - Rotate: vacated bits take the bits shifted out.
  - Shift left: zero fill.
  - Arithmetic right: fill with the sign, bit WIDTH-1 of the original operand, which is carried unchanged through all stages.
- Output: out_data = data of the last stage; out_valid = valid of the last stage. Both are registered; no combinational input-to-output path.
- Advance rule: stage s may load when it is empty or when it will be emptied this cycle.
  - ready_last = !valid_last | out_ready.
  - ready_s = !valid_s | ready_(s+1).
  - in_ready = ready_0.
  - A stage that cannot load holds its contents unchanged. No bubble is inserted when the pipe is stalled and full.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready. A stage whose predecessor is invalid but which is itself ready loads valid = 0.
- Latency:
  - With out_ready held high, an op accepted at clock edge N is presented on out_data/out_valid after edge N+CNT_W-1. That is CNT_W register stages, 4 for the default.
  - Throughput is 1 op per cycle.
- Ordering: results leave in strict acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Capacity: the pipe holds at most CNT_W entries. in_ready is low only when all stages are valid and out_ready is low.
- Count 0: the output equals the input for every op, still with full latency.
- Count WIDTH-1 with arithmetic right: the result is all copies of the sign bit.
- Reset:
  - While rst is high at a clock edge, every valid_s is cleared to 0 and every data/cnt/op register is cleared to 0.
  - Consequently out_valid = 0, out_data = 0 and busy = 0 after that edge. in_ready = 1 on the first cycle after rst is released.
  - Entries in flight when reset asserts mid-operation are discarded and never appear on the output.
  - An input presented while rst is high is not accepted.
- busy = OR of all valid_s.
- Unknown or X inputs while in_valid = 0 must not affect any output.

Test Plan:
- WIDTH=16, op=00, data=0x8001, cnt=4, out_ready=1 -> out_data=0x0018, with out_valid high exactly 4 cycles after acceptance.
- op=01 data=0x8001 cnt=4 -> 0x0010. op=10 data=0x8001 cnt=1 -> 0xC000. op=11 data=0x8000 cnt=15 -> 0xFFFF. op=11 data=0x4000 cnt=2 -> 0x1000.
- Back-to-back stream of 16 ops with random op/cnt/data and out_ready=1 -> one result per cycle, in order, each matching the reference model. cnt=0 returns the data unchanged.
- Hold out_ready=0 while driving 6 valid ops -> exactly 4 are accepted; in_ready drops after the 4th. Then raise out_ready -> the 4 results drain in order, and the remaining 2 ops are accepted as space frees.
- Random out_ready toggling (50%) over 200 ops -> no loss, duplication or reordering; out_data is stable while out_valid & !out_ready.
- Pulse rst for 1 cycle with 3 ops in flight -> out_valid=0, busy=0, out_data=0 next cycle; no flushed result ever appears; the next accepted op completes normally after 4 cycles.
